// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage: req/ack memory port, prefetch FIFO and registered IF/ID outputs.
// Handles redirect flush with in-flight response discard and halts fetch after a memory fault.

module stage_if_prefetch_chk (
   input logic        clk,
   input logic        rst,
   input logic        push,
   input logic        full,
   input logic        mem_req,
   input logic        mem_ack,
   input logic [31:0] mem_addr
);

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

   a_req_stable: assert property (@(posedge clk) disable iff (rst)
      (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

endmodule

module stage_if_prefetch #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] STARTUP_ADDR = 32'hBFC0_0000,
   parameter int unsigned EXC_WIDTH    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 clear,
   input  logic                 jmp_flag,
   input  logic [31:0]          jmp_dest,
   output logic                 mem_req,
   output logic [31:0]          mem_addr,
   input  logic                 mem_ack,
   input  logic [31:0]          mem_data,
   input  logic [EXC_WIDTH-1:0] mem_exc_code,
   output logic                 id_valid,
   output logic [31:0]          id_instr,
   output logic [31:0]          id_next_pc,
   output logic [EXC_WIDTH-1:0] id_exc_code,
   output logic [31:0]          id_exc_addr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE_C  = CW'(1'b1);
   localparam logic [PW-1:0] PTR_ZERO_C = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE_C  = PW'(1'b1);
   localparam logic [EXC_WIDTH-1:0] EC_NONE = {EXC_WIDTH{1'b0}};

   typedef struct packed {
      logic [31:0]          instr;
      logic [31:0]          next_pc;
      logic [EXC_WIDTH-1:0] exc;
      logic [31:0]          addr;
   } entry_t;

   localparam entry_t ENTRY_ZERO_C = '{instr: 32'h0, next_pc: 32'h0, exc: EC_NONE, addr: 32'h0};

   entry_t          fifo_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nxt_s;
   logic [31:0]     pc_r;
   logic [31:0]     req_addr_r;
   logic            outstanding_r;
   logic            drop_r;
   logic            halted_r;
   entry_t          out_r;
   logic            out_valid_r;

   logic            empty_s;
   logic            full_s;
   logic            mem_req_s;
   logic [31:0]     mem_addr_s;
   logic            ack_s;
   logic            push_s;
   logic            fault_s;
   logic            avail_s;
   logic            consume_s;
   logic            fifo_wr_s;
   logic            fifo_rd_s;
   entry_t          new_entry_s;
   entry_t          head_s;

   assign empty_s    = (count_r == CNT_ZERO_C);
   assign full_s     = (count_r == DEPTH_C);
   // A live request keeps its address, even across a redirect, until acknowledged.
   assign mem_addr_s = outstanding_r ? req_addr_r : pc_r;
   assign mem_req_s  = ~rst & (outstanding_r | (~halted_r & ~full_s));
   assign ack_s      = mem_req_s & mem_ack;
   assign push_s     = ack_s & ~drop_r & ~jmp_flag;
   assign fault_s    = (mem_exc_code != EC_NONE);
   // The incoming word counts as the head when the FIFO is empty, giving one-cycle fill latency.
   assign avail_s    = ~empty_s | push_s;
   assign consume_s  = ~stall & ~jmp_flag & avail_s;
   assign fifo_wr_s  = push_s & ~(empty_s & consume_s);
   assign fifo_rd_s  = consume_s & ~empty_s;

   // Build the entry for an accepted response and select the head seen by the output stage
   always_comb begin
      new_entry_s         = ENTRY_ZERO_C;
      new_entry_s.instr   = fault_s ? 32'h0 : mem_data;
      new_entry_s.next_pc = mem_addr_s + 32'd4;
      new_entry_s.exc     = mem_exc_code;
      new_entry_s.addr    = fault_s ? mem_addr_s : 32'h0;
      if (empty_s) begin
         head_s = new_entry_s;
      end else begin
         head_s = fifo_r[rd_ptr_r];
      end
   end

   // Occupancy update from this cycle's write and read
   always_comb begin
      count_nxt_s = count_r;
      case ({fifo_wr_s, fifo_rd_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE_C;
         2'b01:   count_nxt_s = count_r - CNT_ONE_C;
         default: count_nxt_s = count_r;
      endcase
   end

   // Fetch control: pc, outstanding request, drop of a redirected response, fault halt
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r          <= STARTUP_ADDR;
         req_addr_r    <= STARTUP_ADDR;
         outstanding_r <= 1'b0;
         drop_r        <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         outstanding_r <= mem_req_s & ~ack_s;
         req_addr_r    <= mem_addr_s;
         if (jmp_flag) begin
            pc_r     <= jmp_dest;
            halted_r <= 1'b0;
            drop_r   <= mem_req_s & ~ack_s;
         end else if (ack_s) begin
            drop_r <= 1'b0;
            if (!drop_r) begin
               pc_r <= mem_addr_s + 32'd4;
               if (fault_s) begin
                  halted_r <= 1'b1;
               end
            end
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the queue
   always_ff @(posedge clk) begin
      if (rst || jmp_flag) begin
         wr_ptr_r <= PTR_ZERO_C;
         rd_ptr_r <= PTR_ZERO_C;
         count_r  <= CNT_ZERO_C;
      end else begin
         if (fifo_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (fifo_rd_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         count_r <= count_nxt_s;
      end
   end

   // FIFO storage; contents are only read behind a valid count
   always_ff @(posedge clk) begin
      if (!rst && !jmp_flag && fifo_wr_s) begin
         fifo_r[wr_ptr_r] <= new_entry_s;
      end
   end

   // IF/ID output register: holds on stall, bubble on clear/redirect/empty
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r       <= ENTRY_ZERO_C;
         out_valid_r <= 1'b0;
      end else if (!stall) begin
         if (consume_s && !clear) begin
            out_r       <= head_s;
            out_valid_r <= 1'b1;
         end else begin
            out_r       <= ENTRY_ZERO_C;
            out_valid_r <= 1'b0;
         end
      end
   end

   assign mem_req     = mem_req_s;
   assign mem_addr    = mem_addr_s;
   assign id_valid    = out_valid_r;
   assign id_instr    = out_r.instr;
   assign id_next_pc  = out_r.next_pc;
   assign id_exc_code = out_r.exc;
   assign id_exc_addr = out_r.addr;

   stage_if_prefetch_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_wr_s),
      .full     (full_s),
      .mem_req  (mem_req_s),
      .mem_ack  (mem_ack),
      .mem_addr (mem_addr_s)
   );

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: vector table plus hand sequences, with a memory model and
// an output scoreboard fed when responses are acknowledged.
module tb_stage_if_prefetch;

   localparam logic [31:0] START = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        clear = 1'b0;
   logic        jmp_flag = 1'b0;
   logic [31:0] jmp_dest = 32'h0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data = 32'h0;
   logic [4:0]  mem_exc_code = 5'd0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_next_pc;
   logic [4:0]  id_exc_code;
   logic [31:0] id_exc_addr;

   always #5 clk = ~clk;

   stage_if_prefetch #(.DEPTH(4), .STARTUP_ADDR(START), .EXC_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .clear(clear),
      .jmp_flag(jmp_flag), .jmp_dest(jmp_dest),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .mem_exc_code(mem_exc_code),
      .id_valid(id_valid), .id_instr(id_instr), .id_next_pc(id_next_pc),
      .id_exc_code(id_exc_code), .id_exc_addr(id_exc_addr)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] next_pc;
      logic [4:0]  exc;
      logic [31:0] addr;
   } out_t;

   typedef struct packed {
      bit          r, s, c, j;
      logic [31:0] d;
      bit          chk_req, exp_req, chk_addr;
      logic [31:0] exp_addr;
   } vec_t;

   out_t        sb[$];
   out_t        exp_out = '0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          waits = 0;
   int          wait_cnt = 0;
   logic [31:0] fault_addr = 32'h0000_0001;
   bit          drop_m = 1'b0;
   bit          prev_wait = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   vec_t        tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic out_t mk_entry(input logic [31:0] a);
      out_t e;
      e.valid   = 1'b1;
      e.exc     = (a == fault_addr) ? 5'd4 : 5'd0;
      e.instr   = (e.exc != 5'd0) ? 32'h0 : a;
      e.next_pc = a + 32'd4;
      e.addr    = (e.exc != 5'd0) ? a : 32'h0;
      return e;
   endfunction

   function automatic vec_t v(input bit r, s, c, j, input logic [31:0] d,
                              input bit cr, er, ca, input logic [31:0] ea);
      vec_t x;
      x.r = r; x.s = s; x.c = c; x.j = j; x.d = d;
      x.chk_req = cr; x.exp_req = er; x.chk_addr = ca; x.exp_addr = ea;
      return x;
   endfunction

   // One clock cycle: drive, check outputs, answer memory, update the scoreboard.
   task automatic cyc(input vec_t x);
      out_t e;
      bit   acked;
      rst = x.r; stall = x.s; clear = x.c; jmp_flag = x.j; jmp_dest = x.d;
      mem_ack = 1'b0; mem_data = 32'h0; mem_exc_code = 5'd0;
      #1;
      chk("id_valid", {31'd0, id_valid}, {31'd0, exp_out.valid});
      chk("id_instr", id_instr, exp_out.instr);
      chk("id_next_pc", id_next_pc, exp_out.next_pc);
      chk("id_exc_code", {27'd0, id_exc_code}, {27'd0, exp_out.exc});
      chk("id_exc_addr", id_exc_addr, exp_out.addr);
      if (x.chk_req) chk("mem_req", {31'd0, mem_req}, {31'd0, x.exp_req});
      if (x.chk_addr) chk("mem_addr", mem_addr, x.exp_addr);
      if (prev_wait && !x.r) begin
         chk("req_held", {31'd0, mem_req}, 32'd1);
         chk("addr_held", mem_addr, prev_addr);
      end
      if (x.r) begin
         mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; wait_cnt = 0;
      end else if (mem_req) begin
         if (wait_cnt >= waits) begin
            mem_ack = 1'b1;
            mem_data = mem_addr;
            mem_exc_code = (mem_addr == fault_addr) ? 5'd4 : 5'd0;
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      acked = !x.r && mem_req && mem_ack;
      if (x.r) begin
         sb.delete(); exp_out = '0; drop_m = 1'b0;
      end else begin
         if (acked) begin
            if (drop_m) drop_m = 1'b0;
            else if (!x.j) sb.push_back(mk_entry(mem_addr));
         end
         if (x.j) begin
            drop_m = mem_req && !mem_ack;
            sb.delete();
         end
         if (!x.s) begin
            if (!x.j && sb.size() > 0) begin
               e = sb.pop_front();
               exp_out = x.c ? '0 : e;
            end else begin
               exp_out = '0;
            end
         end
      end
      prev_wait = !x.r && mem_req && !mem_ack;
      prev_addr = mem_addr;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input bit s, c, j, input logic [31:0] d,
                      input bit cr, er, ca, input logic [31:0] ea);
      cyc(v(1'b0, s, c, j, d, cr, er, ca, ea));
   endtask

   task automatic do_rst();
      cyc(v(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
   endtask

   initial begin
      // streaming from reset, then 10-cycle stall and release
      tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      for (int k = 0; k < 6; k++)
         tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, START + 32'(4 * k)));
      tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      for (int k = 0; k < 10; k++)
         tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, (k < 4), (k < 4), START + 32'(4 * k)));
      tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      for (int k = 0; k < 6; k++)
         tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, START + 32'h10 + 32'(4 * k)));

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[i]) cyc(tbl[i]);

      // redirect while a request to 0x100 waits three cycles
      do_rst();
      run(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, START);
      waits = 3;
      run(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h100);
      run(1'b0, 1'b0, 1'b1, 32'h2000, 1'b1, 1'b1, 1'b1, 32'h100);
      run(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h100);
      run(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h100);
      waits = 0;
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2000);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2004);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2008);

      // fetch fault at 0x300, halt, resume at 0x80
      do_rst();
      fault_addr = 32'h300;
      run(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, START);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300);
      for (int k = 0; k < 3; k++) run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      run(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
      fault_addr = 32'h0000_0001;
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h84);

      // clear / stall / jump collisions
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h88);
      run(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8C);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h90);
      run(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h94);
      run(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h98);
      run(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h9C);
      run(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 32'hA0);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h400);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h404);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h408);

      // address wrap, then reset in the middle of a waiting request
      run(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1, 32'h40C);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0004);
      waits = 2;
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0008);
      do_rst();
      waits = 0;
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, START);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, START + 32'd4);
      run(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, START + 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
